// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Port indices double as the encoding of the last-grant bit.
package mem_arbiter_pkg;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int LOCK_MAX_DEFAULT = 16;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin select: on contention the port not granted last wins.
module rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic req_c,
   input  logic req_d,
   input  logic last_gnt,
   output logic pick_c,
   output logic pick_d
);

   always_comb begin
      pick_c = req_c & (~req_d | (last_gnt == PORT_D));
      pick_d = req_d & (~req_c | (last_gnt == PORT_C));
   end

endmodule

// File: rtl/mem_arbiter.sv
// Core/DMA arbiter in front of a single-ported data memory, with a bounded
// ownership lock for the DMA port and one-cycle read return.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW       = 32,
   parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [3:0]    c_be,
   input  logic [AW-1:0] c_addr,
   input  logic [31:0]   c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic          c_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic          d_lock,
   input  logic [3:0]    d_be,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_a,
   output logic [31:0]   mem_wd,
   input  logic [31:0]   mem_rd
);

   localparam int CW = $clog2(LOCK_MAX + 1);
   // The granting cycle that enters LOCKED is the first owned cycle, so the
   // counter leaves LOCKED after LOCK_MAX-1 further cycles.
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 2);

   arb_state_t    state_reg, state_next;
   logic [CW-1:0] lock_cnt_reg, lock_cnt_next;
   logic          rearm_reg, rearm_next;
   logic          last_gnt_reg, last_gnt_next;
   logic          c_pend_reg, d_pend_reg;
   logic          pick_c, pick_d;
   logic          lock_hold;

   rr_pick2 u_pick (
      .req_c   (c_req),
      .req_d   (d_req),
      .last_gnt(last_gnt_reg),
      .pick_c  (pick_c),
      .pick_d  (pick_d)
   );

   // A LOCKED cycle with d_lock low is already ordinary open arbitration.
   assign lock_hold = (state_reg == ST_LOCKED) && d_lock;

   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (lock_hold) begin
            d_gnt = d_req;
         end else begin
            c_gnt = pick_c;
            d_gnt = pick_d;
         end
      end
   end

   assign c_stall  = c_req & ~c_gnt;
   assign mem_en   = c_gnt | d_gnt;
   assign rdata    = mem_rd;
   assign c_rvalid = c_pend_reg;
   assign d_rvalid = d_pend_reg;

   always_comb begin
      mem_we = 1'b0;
      mem_be = 4'b0000;
      mem_a  = c_addr;
      mem_wd = c_wdata;
      if (d_gnt) begin
         mem_we = d_we;
         mem_be = d_be;
         mem_a  = d_addr;
         mem_wd = d_wdata;
      end else if (c_gnt) begin
         mem_we = c_we;
         mem_be = c_be;
      end
   end

   always_comb begin
      state_next    = state_reg;
      lock_cnt_next = lock_cnt_reg;
      rearm_next    = rearm_reg | ~d_lock;
      last_gnt_next = last_gnt_reg;
      if (c_gnt) begin
         last_gnt_next = PORT_C;
      end else if (d_gnt) begin
         last_gnt_next = PORT_D;
      end
      case (state_reg)
         ST_OPEN: begin
            if (d_gnt && d_lock && rearm_reg) begin
               state_next    = ST_LOCKED;
               lock_cnt_next = '0;
            end
         end
         ST_LOCKED: begin
            if (!d_lock) begin
               state_next = ST_OPEN;
            end else if (lock_cnt_reg == LOCK_LAST) begin
               // Forced release: core gets the next contention and the
               // DMA must drop d_lock before it can lock again.
               state_next    = ST_OPEN;
               rearm_next    = 1'b0;
               last_gnt_next = PORT_D;
            end else begin
               lock_cnt_next = lock_cnt_reg + CW'(1);
            end
         end
         default: state_next = ST_OPEN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_OPEN;
         lock_cnt_reg <= '0;
         rearm_reg    <= 1'b1;
         last_gnt_reg <= PORT_D;
         c_pend_reg   <= 1'b0;
         d_pend_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lock_cnt_reg <= lock_cnt_next;
         rearm_reg    <= rearm_next;
         last_gnt_reg <= last_gnt_next;
         c_pend_reg   <= c_gnt & ~c_we;
         d_pend_reg   <= d_gnt & ~d_we;
      end
   end

endmodule
